// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard controller.
// Holds the FSM encoding and register/counter widths.
package pipe_ctrl_pkg;
    localparam int REG_W   = 5;
    localparam int CNT_W   = 16;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } hazState_e;
endpackage

// File: rtl/sat_counter16.sv
// Saturating up-counter with enable and async active-low reset.
// Holds at all-ones instead of wrapping.
module sat_counter16
    import pipe_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use, control-flow and memory-wait hazard controller.
// Drives pipeline register enables/flushes and perf counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 255
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             iIDEX_MemRead,
    input  logic [REG_W-1:0] iIDEX_Rt,
    input  logic [REG_W-1:0] iIFID_Rs,
    input  logic [REG_W-1:0] iIFID_Rt,
    input  logic             iIFID_UsesRt,
    input  logic             iBranchTaken,
    input  logic             iJump,
    input  logic             iHalt,
    input  logic             iMemBusy,
    output logic             oPCEnable,
    output logic             oIFIDEnable,
    output logic             oIDEXEnable,
    output logic             oEXMEMEnable,
    output logic             oMEMWBEnable,
    output logic             oIFIDFlush,
    output logic             oIDEXFlush,
    output logic [CNT_W-1:0] oStallCount,
    output logic [CNT_W-1:0] oFlushCount,
    output logic             oHalted,
    output logic             oError,
    output logic [1:0]       oState
);
    hazState_e state, nextState;
    logic [2:0] stallRem, nextRem;
    logic [7:0] waitCnt, nextWait;
    logic       halted, error, setErr;
    logic       luHazard, flushInc, stallInc;
    logic       pcEn, ifidEn, idexEn, exmemEn, memwbEn;
    logic       ifidFl, idexFl;

    assign luHazard = iIDEX_MemRead && (iIDEX_Rt != '0) &&
                      ((iIDEX_Rt == iIFID_Rs) ||
                       (iIFID_UsesRt && (iIDEX_Rt == iIFID_Rt)));

    always_comb begin
        pcEn      = 1'b0;
        ifidEn    = 1'b0;
        idexEn    = 1'b0;
        exmemEn   = 1'b0;
        memwbEn   = 1'b0;
        ifidFl    = 1'b0;
        idexFl    = 1'b0;
        flushInc  = 1'b0;
        setErr    = 1'b0;
        nextState = state;
        nextRem   = stallRem;
        nextWait  = waitCnt;
        unique case (state)
            RUN, MEM_WAIT: begin
                if (state == MEM_WAIT && iMemBusy) begin
                    nextWait = waitCnt + 8'd1;
                    if (nextWait == 8'(MEM_TIMEOUT)) begin
                        nextState = HALT;
                        setErr    = 1'b1;
                    end
                end else if (iMemBusy) begin
                    nextWait = 8'd1;
                    if (MEM_TIMEOUT == 1) begin
                        nextState = HALT;
                        setErr    = 1'b1;
                    end else begin
                        nextState = MEM_WAIT;
                    end
                end else begin
                    nextWait  = 8'd0;
                    nextState = RUN;
                    pcEn      = 1'b1;
                    ifidEn    = 1'b1;
                    idexEn    = 1'b1;
                    exmemEn   = 1'b1;
                    memwbEn   = 1'b1;
                    if (iBranchTaken) begin
                        ifidFl   = 1'b1;
                        idexFl   = 1'b1;
                        flushInc = 1'b1;
                    end else if (luHazard) begin
                        pcEn   = 1'b0;
                        ifidEn = 1'b0;
                        idexFl = 1'b1;
                        if (LU_STALL_CYCLES > 1) begin
                            nextState = STALL;
                            nextRem   = 3'(LU_STALL_CYCLES - 1);
                        end
                    end else if (iHalt) begin
                        nextState = HALT;
                    end else if (iJump) begin
                        ifidFl   = 1'b1;
                        flushInc = 1'b1;
                    end
                end
            end
            STALL: begin
                if (!iMemBusy) begin
                    idexEn  = 1'b1;
                    exmemEn = 1'b1;
                    memwbEn = 1'b1;
                    idexFl  = 1'b1;
                    if (stallRem <= 3'd1) begin
                        nextRem   = 3'd0;
                        nextState = RUN;
                    end else begin
                        nextRem = stallRem - 3'd1;
                    end
                end
            end
            HALT: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            stallRem <= '0;
            waitCnt  <= '0;
            halted   <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= nextState;
            stallRem <= nextRem;
            waitCnt  <= nextWait;
            halted   <= (nextState == HALT);
            error    <= error | setErr;
        end
    end

    // Reset overrides the state-derived controls immediately.
    assign oPCEnable    = reset_n & pcEn;
    assign oIFIDEnable  = reset_n & ifidEn;
    assign oIDEXEnable  = reset_n & idexEn;
    assign oEXMEMEnable = reset_n & exmemEn;
    assign oMEMWBEnable = reset_n & memwbEn;
    assign oIFIDFlush   = reset_n & ifidFl;
    assign oIDEXFlush   = reset_n & idexFl;
    assign oHalted      = halted;
    assign oError       = error;
    assign oState       = state;

    assign stallInc = (state != HALT) && !pcEn;

    sat_counter16 uStallCnt (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (stallInc),
        .count   (oStallCount)
    );

    sat_counter16 uFlushCnt (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (flushInc),
        .count   (oFlushCount)
    );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Vector table plus multi-cycle hazard/reset/timeout sequences.
module tb_pipeline_hazard_ctrl;
    logic clock = 1'b0;
    logic reset_n;
    logic memRead;
    logic [4:0] exRt, idRs, idRt;
    logic usesRt, br, jmp, hlt, busy;

    logic pc1, ifid1, idex1, exmem1, memwb1, ifidFl1, idexFl1;
    logic [15:0] stallCnt1, flushCnt1;
    logic halted1, error1;
    logic [1:0] state1;

    logic pc3, ifid3, idex3, exmem3, memwb3, ifidFl3, idexFl3;
    logic [15:0] stallCnt3, flushCnt3;
    logic halted3, error3;
    logic [1:0] state3;

    logic [6:0] ctl1, ctl3;
    assign ctl1 = {pc1, ifid1, idex1, exmem1, memwb1, ifidFl1, idexFl1};
    assign ctl3 = {pc3, ifid3, idex3, exmem3, memwb3, ifidFl3, idexFl3};

    localparam logic [6:0] ALLEN  = 7'b11111_00;
    localparam logic [6:0] BUBBLE = 7'b00111_01;
    localparam logic [6:0] BRFL   = 7'b11111_11;
    localparam logic [6:0] JMPFL  = 7'b11111_10;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(255)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .iIDEX_MemRead(memRead), .iIDEX_Rt(exRt),
        .iIFID_Rs(idRs), .iIFID_Rt(idRt), .iIFID_UsesRt(usesRt),
        .iBranchTaken(br), .iJump(jmp), .iHalt(hlt), .iMemBusy(busy),
        .oPCEnable(pc1), .oIFIDEnable(ifid1), .oIDEXEnable(idex1),
        .oEXMEMEnable(exmem1), .oMEMWBEnable(memwb1),
        .oIFIDFlush(ifidFl1), .oIDEXFlush(idexFl1),
        .oStallCount(stallCnt1), .oFlushCount(flushCnt1),
        .oHalted(halted1), .oError(error1), .oState(state1)
    );

    pipeline_hazard_ctrl #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(255)) dut3 (
        .clock(clock), .reset_n(reset_n),
        .iIDEX_MemRead(memRead), .iIDEX_Rt(exRt),
        .iIFID_Rs(idRs), .iIFID_Rt(idRt), .iIFID_UsesRt(usesRt),
        .iBranchTaken(br), .iJump(jmp), .iHalt(hlt), .iMemBusy(busy),
        .oPCEnable(pc3), .oIFIDEnable(ifid3), .oIDEXEnable(idex3),
        .oEXMEMEnable(exmem3), .oMEMWBEnable(memwb3),
        .oIFIDFlush(ifidFl3), .oIDEXFlush(idexFl3),
        .oStallCount(stallCnt3), .oFlushCount(flushCnt3),
        .oHalted(halted3), .oError(error3), .oState(state3)
    );

    typedef struct {
        logic       mr;
        logic [4:0] xRt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       b;
        logic       j;
        logic [6:0] ctl;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        memRead = 0; exRt = 0; idRs = 0; idRt = 0; usesRt = 0;
        br = 0; jmp = 0; hlt = 0; busy = 0;
    endtask

    task automatic hazard();
        idle();
        memRead = 1; exRt = 5'd5; idRs = 5'd5;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        idle();
        reset_n = 0;
        #1;
        chk("rst_ctl1", {25'd0, ctl1}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1;
        tick();
    endtask

    initial begin
        int expStall;
        int expFlush;
        logic allZero;

        vecs[0]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, ALLEN};
        vecs[1]  = '{1, 5'd5, 5'd5, 5'd0, 0, 0, 0, BUBBLE};
        vecs[2]  = '{1, 5'd7, 5'd3, 5'd7, 1, 0, 0, BUBBLE};
        vecs[3]  = '{1, 5'd7, 5'd3, 5'd7, 0, 0, 0, ALLEN};
        vecs[4]  = '{1, 5'd0, 5'd0, 5'd0, 0, 0, 0, ALLEN};
        vecs[5]  = '{0, 5'd5, 5'd5, 5'd5, 1, 0, 0, ALLEN};
        vecs[6]  = '{0, 5'd0, 5'd1, 5'd2, 0, 1, 0, BRFL};
        vecs[7]  = '{0, 5'd0, 5'd1, 5'd2, 0, 0, 1, JMPFL};
        vecs[8]  = '{1, 5'd5, 5'd5, 5'd0, 0, 1, 0, BRFL};
        vecs[9]  = '{1, 5'd5, 5'd5, 5'd0, 0, 0, 1, BUBBLE};
        vecs[10] = '{0, 5'd0, 5'd0, 5'd0, 0, 1, 1, BRFL};

        doReset();
        chk("rst_state", {30'd0, state1}, 32'd0);
        chk("rst_stall", {16'd0, stallCnt1}, 32'd0);
        chk("rst_flush", {16'd0, flushCnt1}, 32'd0);
        chk("rst_flags", {30'd0, halted1, error1}, 32'd0);

        expStall = 0;
        expFlush = 0;
        for (int i = 0; i < 11; i++) begin
            idle();
            memRead = vecs[i].mr; exRt = vecs[i].xRt;
            idRs = vecs[i].rs; idRt = vecs[i].rt;
            usesRt = vecs[i].uses; br = vecs[i].b; jmp = vecs[i].j;
            #1;
            chk($sformatf("vec%0d_ctl", i), {25'd0, ctl1},
                {25'd0, vecs[i].ctl});
            if (!vecs[i].ctl[6]) expStall++;
            if (vecs[i].ctl[1]) expFlush++;
            tick();
            chk($sformatf("vec%0d_state", i), {30'd0, state1}, 32'd0);
        end
        chk("tbl_stall", {16'd0, stallCnt1}, expStall);
        chk("tbl_flush", {16'd0, flushCnt1}, expFlush);

        doReset();
        hazard();
        #1;
        chk("lu1_ctl", {25'd0, ctl1}, {25'd0, BUBBLE});
        tick();
        idle();
        #1;
        chk("lu1_after", {25'd0, ctl1}, {25'd0, ALLEN});
        chk("lu1_stall", {16'd0, stallCnt1}, 32'd1);
        chk("lu1_state", {30'd0, state1}, 32'd0);

        doReset();
        hazard();
        #1;
        chk("lu3_c0", {25'd0, ctl3}, {25'd0, BUBBLE});
        tick();
        idle();
        chk("lu3_st", {30'd0, state3}, 32'd1);
        #1;
        chk("lu3_c1", {25'd0, ctl3}, {25'd0, BUBBLE});
        tick();
        #1;
        chk("lu3_c2", {25'd0, ctl3}, {25'd0, BUBBLE});
        tick();
        chk("lu3_run", {30'd0, state3}, 32'd0);
        #1;
        chk("lu3_c3", {25'd0, ctl3}, {25'd0, ALLEN});
        chk("lu3_stall", {16'd0, stallCnt3}, 32'd3);

        doReset();
        hazard();
        tick();
        idle();
        busy = 1; br = 1; jmp = 1; hlt = 1;
        #1;
        chk("stb_frz", {25'd0, ctl3}, 32'd0);
        tick();
        chk("stb_st", {30'd0, state3}, 32'd1);
        idle();
        #1;
        chk("stb_b1", {25'd0, ctl3}, {25'd0, BUBBLE});
        tick();
        #1;
        chk("stb_b2", {25'd0, ctl3}, {25'd0, BUBBLE});
        tick();
        chk("stb_run", {30'd0, state3}, 32'd0);
        chk("stb_stall", {16'd0, stallCnt3}, 32'd4);
        chk("stb_flush", {16'd0, flushCnt3}, 32'd0);

        doReset();
        hazard();
        br = 1;
        #1;
        chk("brlu_ctl", {25'd0, ctl1}, {25'd0, BRFL});
        tick();
        idle();
        chk("brlu_flush", {16'd0, flushCnt1}, 32'd1);
        chk("brlu_stall", {16'd0, stallCnt1}, 32'd0);

        doReset();
        busy = 1;
        allZero = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ctl1 != 7'd0) allZero = 0;
            tick();
        end
        chk("busy4_frz", {31'd0, allZero}, 32'd1);
        chk("busy4_st", {30'd0, state1}, 32'd2);
        busy = 0;
        #1;
        chk("busy4_res", {25'd0, ctl1}, {25'd0, ALLEN});
        tick();
        chk("busy4_run", {30'd0, state1}, 32'd0);
        chk("busy4_stall", {16'd0, stallCnt1}, 32'd4);

        doReset();
        hazard();
        tick();
        idle();
        #2;
        reset_n = 0;
        #1;
        chk("mid_ctl", {25'd0, ctl3}, 32'd0);
        chk("mid_st", {30'd0, state3}, 32'd0);
        chk("mid_cnt", {16'd0, stallCnt3}, 32'd0);
        @(negedge clock);
        reset_n = 1;
        tick();
        #1;
        chk("mid_after", {25'd0, ctl3}, {25'd0, ALLEN});
        tick();
        chk("mid_run", {30'd0, state3}, 32'd0);

        doReset();
        hlt = 1;
        #1;
        chk("hlt_ctl", {25'd0, ctl1}, {25'd0, ALLEN});
        tick();
        idle();
        #1;
        chk("hlt_st", {30'd0, state1}, 32'd3);
        chk("hlt_flags", {30'd0, halted1, error1}, 32'b10);
        chk("hlt_ctl2", {25'd0, ctl1}, 32'd0);

        doReset();
        busy = 1;
        allZero = 1;
        for (int i = 0; i < 254; i++) begin
            #1;
            if (ctl1 != 7'd0) allZero = 0;
            tick();
        end
        chk("to_pre_st", {30'd0, state1}, 32'd2);
        chk("to_pre_hlt", {31'd0, halted1}, 32'd0);
        tick();
        chk("to_frz", {31'd0, allZero}, 32'd1);
        chk("to_st", {30'd0, state1}, 32'd3);
        chk("to_flags", {30'd0, halted1, error1}, 32'b11);
        chk("to_stall", {16'd0, stallCnt1}, 32'd255);
        busy = 0;
        #1;
        chk("to_ctl", {25'd0, ctl1}, 32'd0);
        tick();
        chk("to_stay", {30'd0, state1}, 32'd3);
        doReset();
        chk("to_clr", {30'd0, halted1, error1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
